axi_rd_burst_engine: RTL

// - AXI4 read master directly downstream of the memcpy burst splitter: consumes burst_start/burst_addr/burst_len.
// - Issues one INCR AR transaction per burst and collects the R beats into an internal FIFO.
// - Streams the beats out on a valid/ready data port.
// - Returns burst_busy and a burst_done pulse so the splitter can sequence 4KB-bounded bursts.

---
 rtl/axi_rd_burst_engine_pkg.sv | 23 ++
 rtl/axi_rd_burst_engine_fifo.sv | 56 +++++
 rtl/axi_rd_burst_engine.sv | 133 +++++++++++++
 3 files changed

// File: rtl/axi_rd_burst_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_burst_engine_pkg
// Description : Shared AXI encodings and FSM state type for the read burst
//               engine and its data FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_burst_engine_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_64B   = 3'd6;

    // One-hot encoding keeps every state decode to a single flop bit.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ADDR = 4'b0010,
        ST_DATA = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_rd_burst_engine_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rd_data_fifo
// Description : Synchronous FIFO buffering AXI R beats. The head entry is read
//               straight out of the registered storage, so a beat written in
//               one cycle is visible at dout in the next one.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_data_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; reset empties the FIFO without touching the storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; data array needs no reset since the pointers gate it.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_burst_engine.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_burst_engine
// Description : AXI4 read master. Issues one INCR AR per requested burst,
//               buffers R beats in a FIFO and streams them on dout. Reports
//               busy, a done pulse and a sticky protocol error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_burst_engine
    import axi_rd_burst_engine_pkg::*;
#(
    parameter int              ADDR_W     = 64,
    parameter int              DATA_W     = 512,
    parameter int              ID_W       = 4,
    parameter logic [ID_W-1:0] AXI_ID     = '0,
    parameter int              FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_addr,
    input  logic [7:0]        burst_len,
    output logic              burst_busy,
    output logic              burst_done,
    output logic              rd_err,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [ID_W-1:0]   m_arid,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam logic [2:0] c_ARSIZE = 3'($clog2(DATA_W / 8));

    state_t     r_state;
    logic [7:0] r_beat_cnt;
    logic       w_full;
    logic       w_empty;
    logic       w_beat;

    assign m_arsize   = c_ARSIZE;
    assign m_arburst  = AXI_BURST_INCR;
    assign m_arid     = AXI_ID;
    assign m_rready   = !w_full && (r_state == ST_DATA);
    assign w_beat     = m_rvalid && m_rready;
    assign dout_valid = !w_empty;

    // Burst sequencing, AR channel registers, beat counting and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            m_araddr   <= '0;
            m_arlen    <= '0;
            m_arvalid  <= 1'b0;
            burst_busy <= 1'b0;
            burst_done <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (burst_start) begin
                        m_araddr   <= burst_addr;
                        // A zero length request is run as a single beat.
                        m_arlen    <= (burst_len == 8'd0) ? 8'd0 : burst_len - 8'd1;
                        if (burst_len == 8'd0) rd_err <= 1'b1;
                        m_arvalid  <= 1'b1;
                        burst_busy <= 1'b1;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        m_arvalid  <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        if (m_rresp != AXI_RESP_OKAY) rd_err <= 1'b1;
                        if (m_rlast) begin
                            // The burst ends on rlast even when it is misplaced.
                            if (r_beat_cnt != m_arlen) rd_err <= 1'b1;
                            burst_done <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            if (r_beat_cnt == m_arlen) rd_err <= 1'b1;
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    burst_done <= 1'b0;
                    burst_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    burst_done <= 1'b0;
                    burst_busy <= 1'b0;
                    m_arvalid  <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    rd_data_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_beat),
        .push_data (m_rdata),
        .pop       (dout_ready),
        .dout      (dout),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire
